// File: rtl/cos_pkg.sv
// Shared definitions for the cosine/distance engine arbiter: Q5.11 format,
// default engine timeout and the arbiter state encoding.
package cos_pkg;

  localparam int INT_BITS        = 5;
  localparam int FRAC_BITS       = 11;
  localparam int Q_WIDTH         = INT_BITS + FRAC_BITS;
  localparam int DEFAULT_TIMEOUT = 63;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    ABORT = 3'd4
  } state_t;

endpackage

// File: rtl/cos_arbiter_rr_pick.sv
// Round-robin selector: first set request bit searching upward from ptr,
// wrapping past the top requester back to zero.
module rr_pick
  import cos_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cos_arbiter.sv
// Shares one cosine/distance engine among NREQ requesters: round-robin grant,
// operand capture, engine start/timeout supervision and one-hot response.
module cos_arbiter
  import cos_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = Q_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] v_in,
  input  logic [NREQ*W-1:0] x_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_distance,
  output logic              rsp_error,
  output logic              eng_start,
  output logic [W-1:0]      eng_vSig,
  output logic [W-1:0]      eng_XSig,
  output logic              eng_abort,
  input  logic              eng_done,
  input  logic [W-1:0]      eng_distance
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   id;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_grant;
  logic            pick_valid;
  logic [CW-1:0]   cnt;
  logic            done_q;
  logic            err_q;
  logic            done_edge;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) pick_idx = PW'(i);
    end
  end

  // A done level already high when WAIT is entered is not an edge, so a
  // stale done from the previous job cannot complete this one.
  assign done_edge = eng_done && !done_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (done_edge)            state_nxt = RESP;
        else if (cnt == CNT_LAST) state_nxt = ABORT;
      end
      ABORT:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      id           <= '0;
      cnt          <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rsp_distance <= '0;
      eng_vSig     <= '0;
      eng_XSig     <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= eng_done;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            id       <= pick_idx;
            eng_vSig <= v_in[int'(pick_idx)*W +: W];
            eng_XSig <= x_in[int'(pick_idx)*W +: W];
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (done_edge) begin
            rsp_distance <= eng_distance;
            err_q        <= 1'b0;
          end
        end
        ABORT: begin
          rsp_distance <= '0;
          err_q        <= 1'b1;
        end
        RESP: ptr <= (id == PW'(NREQ - 1)) ? '0 : id + 1'b1;
        default: ;
      endcase
    end
  end

  // Grant is combinational in IDLE; held off during reset so nothing is
  // accepted while the block is being cleared.
  assign gnt       = (state == IDLE && rst) ? pick_grant : '0;
  assign eng_start = (state == ISSUE);
  assign eng_abort = (state == ABORT);
  assign rsp_valid = (state == RESP) ? (NREQ'(1) << id) : '0;
  assign rsp_error = (state == RESP) && err_q;

endmodule

// File: tb/tb_cos_arbiter.sv
// Self-checking bench for cos_arbiter: vector table, reset and rotation
// sequences, and randomized jobs against a transaction-level model.
module tb_cos_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 16;
  localparam int TIMEOUT = 63;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] v_in = '0;
  logic [NREQ*W-1:0] x_in = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_distance;
  logic              rsp_error;
  logic              eng_start;
  logic [W-1:0]      eng_vSig;
  logic [W-1:0]      eng_XSig;
  logic              eng_abort;
  logic              eng_done = 1'b0;
  logic [W-1:0]      eng_distance = '0;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  int eng_delay = 1;
  bit eng_stuck = 1'b0;
  int eng_cnt = 0;
  bit eng_active = 1'b0;

  cos_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .v_in         (v_in),
    .x_in         (x_in),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_distance (rsp_distance),
    .rsp_error    (rsp_error),
    .eng_start    (eng_start),
    .eng_vSig     (eng_vSig),
    .eng_XSig     (eng_XSig),
    .eng_abort    (eng_abort),
    .eng_done     (eng_done),
    .eng_distance (eng_distance)
  );

  always #5 clk = ~clk;

  // Engine model: done rises eng_delay cycles after the start cycle. In stuck
  // mode done stays high through start and dips for one cycle before rising.
  always @(negedge clk) begin
    if (eng_start) begin
      eng_cnt    = eng_delay;
      eng_active = 1'b1;
      if (!eng_stuck) eng_done = 1'b0;
    end else if (eng_active) begin
      eng_cnt = eng_cnt - 1;
      if (eng_stuck && eng_cnt == 1) eng_done = 1'b0;
      if (eng_cnt == 0) begin
        eng_done     = 1'b1;
        eng_distance = eng_vSig - eng_XSig;
        eng_active   = 1'b0;
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NREQ*W-1:0] fill(input logic [W-1:0] base);
    logic [NREQ*W-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) r[i*W +: W] = base + W'(i * 273);
    return r;
  endfunction

  function automatic logic [NREQ-1:0] model_pick(input logic [NREQ-1:0] r, input int p);
    logic [NREQ-1:0] g;
    g = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (g == '0 && r[(p + k) % NREQ]) g[(p + k) % NREQ] = 1'b1;
    end
    return g;
  endfunction

  // One whole job: grant in the IDLE cycle, start next cycle, then either a
  // response delay+1 cycles after start or an abort TIMEOUT+1 cycles after start.
  task automatic apply_stimulus(input logic [NREQ-1:0] req_pat, input logic [NREQ*W-1:0] vf,
                                input logic [NREQ*W-1:0] xf, input int delay, input bit stuck,
                                input logic [NREQ-1:0] exp_gnt, input bit exp_err, input string name);
    int idx;
    int rk;
    logic [W-1:0] ev, ex, edist;
    @(posedge clk); #1;
    req = req_pat; v_in = vf; x_in = xf; eng_delay = delay; eng_stuck = stuck;
    #1;
    check_output({name, " gnt"}, 64'(gnt), 64'(exp_gnt));
    idx = 0;
    for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) idx = i;
    ev    = vf[idx*W +: W];
    ex    = xf[idx*W +: W];
    edist = exp_err ? '0 : W'(ev - ex);
    rk    = exp_err ? TIMEOUT + 2 : delay + 1;
    @(posedge clk); #2;
    check_output({name, " start"}, {gnt, rsp_valid, eng_start, eng_abort, eng_vSig, eng_XSig},
                 {4'b0, 4'b0, 1'b1, 1'b0, ev, ex});
    for (int k = 1; k < rk; k++) begin
      @(posedge clk); #2;
      check_output({name, " busy"}, {gnt, rsp_valid, eng_start, eng_abort, eng_vSig, eng_XSig},
                   {4'b0, 4'b0, 1'b0, (exp_err && k == TIMEOUT + 1), ev, ex});
    end
    @(posedge clk); #2;
    check_output({name, " resp"}, {gnt, rsp_valid, rsp_error, rsp_distance, eng_abort, eng_start},
                 {4'b0, exp_gnt, exp_err, edist, 2'b00});
    model_ptr = (idx + 1) % NREQ;
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    logic [W-1:0]    v;
    logic [W-1:0]    x;
    int              delay;
    bit              stuck;
    logic [NREQ-1:0] gnt;
    bit              err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [NREQ-1:0]   r;
    logic [NREQ*W-1:0] vf, xf;
    int                d;

    vecs[0] = '{4'b0001, 16'h0800, 16'h0400, 18,   1'b0, 4'b0001, 1'b0};
    vecs[1] = '{4'b1111, 16'h1000, 16'h0200, 5,    1'b0, 4'b0010, 1'b0};
    vecs[2] = '{4'b1111, 16'h0123, 16'h0042, 63,   1'b0, 4'b0100, 1'b0};
    vecs[3] = '{4'b1111, 16'h7000, 16'h0001, 200,  1'b0, 4'b1000, 1'b1};
    vecs[4] = '{4'b1111, 16'h8000, 16'h7FFF, 3,    1'b0, 4'b0001, 1'b0};
    vecs[5] = '{4'b0001, 16'h0ABC, 16'h0CBA, 1,    1'b0, 4'b0001, 1'b0};
    vecs[6] = '{4'b0101, 16'hFFFF, 16'h0001, 7,    1'b0, 4'b0100, 1'b0};
    vecs[7] = '{4'b0011, 16'h0555, 16'h0111, 10,   1'b1, 4'b0001, 1'b0};
    vecs[8] = '{4'b0010, 16'h0333, 16'h0222, 1000, 1'b1, 4'b0010, 1'b1};
    vecs[9] = '{4'b0100, 16'h0444, 16'h0100, 64,   1'b0, 4'b0100, 1'b1};

    // Power-on reset with requests pending: nothing may be granted.
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset state", {gnt, rsp_valid, rsp_error, rsp_distance, eng_start, eng_abort, eng_vSig, eng_XSig}, '0);
    @(negedge clk);
    rst = 1'b1;
    req = '0;

    for (int n = 0; n < 10; n++) begin
      apply_stimulus(vecs[n].req, fill(vecs[n].v), fill(vecs[n].x), vecs[n].delay, vecs[n].stuck,
                     vecs[n].gnt, vecs[n].err, $sformatf("vec%0d", n));
    end

    // Reset in the middle of a WAIT discards the job.
    @(posedge clk); #1;
    req = 4'b0001; v_in = fill(16'hF400); x_in = fill(16'h0946); eng_delay = 30; eng_stuck = 1'b0;
    @(posedge clk); #1;
    req = '0;
    repeat (10) @(posedge clk);
    #3;
    req = 4'b1111;
    rst = 1'b0;
    #1;
    check_output("reset mid-job", {gnt, rsp_valid, rsp_error, rsp_distance, eng_start, eng_abort, eng_vSig, eng_XSig}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #2;
      check_output("no rsp after reset", {rsp_valid, rsp_error, eng_start, eng_abort}, '0);
    end
    model_ptr = 0;

    // All requesters held continuously: strict rotation from pointer zero.
    apply_stimulus(4'b1111, fill(16'h0100), fill(16'h0010), 4, 1'b0, 4'b0001, 1'b0, "rot0");
    apply_stimulus(4'b1111, fill(16'h0200), fill(16'h0020), 6, 1'b0, 4'b0010, 1'b0, "rot1");
    apply_stimulus(4'b1111, fill(16'h0300), fill(16'h0030), 2, 1'b0, 4'b0100, 1'b0, "rot2");
    apply_stimulus(4'b1111, fill(16'h0400), fill(16'h0040), 9, 1'b0, 4'b1000, 1'b0, "rot3");
    apply_stimulus(4'b1111, fill(16'h0500), fill(16'h0050), 3, 1'b0, 4'b0001, 1'b0, "rot4");

    for (int n = 0; n < 16; n++) begin
      r  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      d  = int'($urandom_range(1, TIMEOUT + 4));
      vf = {$urandom, $urandom};
      xf = {$urandom, $urandom};
      apply_stimulus(r, vf, xf, d, 1'b0, model_pick(r, model_ptr), d > TIMEOUT, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
